// File: rtl/race_max_seq.sv
// Gamma-cycle sequencer driving edge-coded race lines into a max unit.
// Define RACE_FALLING_EN for falling-edge coding (idle high, active low).
module race_max_seq #(
    parameter int N_IN = 2,
    parameter int T_W  = 4
) (
    input  logic                aclk,
    input  logic                grst,
    input  logic                start,
    input  logic [N_IN*T_W-1:0] times,
    output logic                busy,
    output logic [N_IN-1:0]     edge_out,
    input  logic                y,
    output logic                done,
    output logic [T_W-1:0]      result,
    output logic                spike
);

    localparam logic [T_W-1:0] INF  = {T_W{1'b1}};
    localparam logic [T_W-1:0] LAST = INF - T_W'(1);

`ifdef RACE_FALLING_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CLEAR
    } state_t;

    state_t              state;
    logic [T_W-1:0]      cnt;
    logic [N_IN*T_W-1:0] tlat;
    logic                fired;

    assign fired = (y != IDLE_LVL);
    assign busy  = (state != IDLE);

    // Lines decode only from registered state, never from start/times.
    always_comb begin
        edge_out = {N_IN{IDLE_LVL}};
        for (int i = 0; i < N_IN; i++) begin
            if (state == RUN && tlat[i*T_W +: T_W] != INF &&
                tlat[i*T_W +: T_W] <= cnt) begin
                edge_out[i] = ~IDLE_LVL;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!grst) begin
            state  <= IDLE;
            cnt    <= '0;
            tlat   <= '0;
            done   <= 1'b0;
            result <= INF;
            spike  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tlat  <= times;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fired) begin
                        result <= cnt;
                        spike  <= 1'b1;
                        done   <= 1'b1;
                        state  <= CLEAR;
                    end else if (cnt == LAST) begin
                        result <= INF;
                        spike  <= 1'b0;
                        done   <= 1'b1;
                        state  <= CLEAR;
                    end else begin
                        cnt <= cnt + T_W'(1);
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
